cordic_rr_sched: RTL and testbench

- Shares one pipelined 16-bit CORDIC rotator between NREQ requesters, such as DDC/DUC channels or test-tone generators.
- Round-robin arbitration issues at most one sample per clock into the rotator.
- A tag pipeline matched to the rotator latency steers each result back with its channel id.
- Sits between the per-channel sample sources and a single cordic instance; the rotator has no flow control, so results are never back-pressured.

---
 rtl/cordic_rr_sched_pkg.sv | 21 ++
 rtl/cordic_rr_sched_arb.sv | 33 +++
 rtl/cordic_rr_sched.sv | 134 +++++++++++++
 tb/tb_cordic_rr_sched.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_rr_sched_pkg.sv
// Shared definitions for the round-robin CORDIC scheduler: rotator latency,
// a clog2 helper and the packed tag layout {valid, chan}.
package cordic_rr_sched_pkg;

  localparam int CORDIC_LATENCY = 13;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Tag is packed as {valid, chan[cw-1:0]}, valid in the MSB.
  function automatic int tag_width(input int cw);
    return cw + 1;
  endfunction

endpackage

// File: rtl/cordic_rr_sched_arb.sv
// Combinational round-robin arbiter: grants the first eligible requester
// searching upward from ptr with wrap-around.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int CW   = 2
) (
  input  logic [NREQ-1:0] elig,
  input  logic [CW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [CW-1:0]   grant_idx,
  output logic            grant_any
);

  logic [CW-1:0] idx;
  logic          found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = CW'((int'(ptr) + k) % NREQ);
      if (!found && elig[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
    grant_any = found;
  end

endmodule

// File: rtl/cordic_rr_sched.sv
// Shares one pipelined CORDIC rotator between NREQ requesters; a tag pipe
// matched to the rotator latency returns each result with its channel id.
module cordic_rr_sched
  import cordic_rr_sched_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int BITWIDTH = 16,
  parameter int ZWIDTH   = 16,
  parameter int LATENCY  = CORDIC_LATENCY,
  parameter int CW       = clog2(NREQ)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NREQ-1:0]          chan_mask,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*BITWIDTH-1:0] req_x,
  input  logic [NREQ*BITWIDTH-1:0] req_y,
  input  logic [NREQ*ZWIDTH-1:0]   req_z,
  output logic [BITWIDTH-1:0]      cor_xi,
  output logic [BITWIDTH-1:0]      cor_yi,
  output logic [ZWIDTH-1:0]        cor_zi,
  input  logic [BITWIDTH-1:0]      cor_xo,
  input  logic [BITWIDTH-1:0]      cor_yo,
  input  logic [ZWIDTH-1:0]        cor_zo,
  output logic                     res_valid,
  output logic [CW-1:0]            res_chan,
  output logic [BITWIDTH-1:0]      res_x,
  output logic [BITWIDTH-1:0]      res_y,
  output logic [ZWIDTH-1:0]        res_z,
  output logic                     busy
);

  localparam int TW = tag_width(CW);

  logic [CW-1:0]       ptr;
  logic [NREQ-1:0]     elig;
  logic [NREQ-1:0]     grant;
  logic [CW-1:0]       grant_idx;
  logic                grant_any;
  logic                transfer;
  logic [BITWIDTH-1:0] sel_x;
  logic [BITWIDTH-1:0] sel_y;
  logic [ZWIDTH-1:0]   sel_z;
  logic [TW-1:0]       issue_tag;
  logic [TW-1:0]       tag_pipe [LATENCY];
  logic [TW-1:0]       tag_out;

  assign elig = req_valid & chan_mask;

  rr_arbiter #(
    .NREQ (NREQ),
    .CW   (CW)
  ) u_arb (
    .elig      (elig),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign req_ready = reset ? '0 : grant;
  assign transfer  = grant_any & ~reset;

  assign sel_x = req_x[grant_idx*BITWIDTH +: BITWIDTH];
  assign sel_y = req_y[grant_idx*BITWIDTH +: BITWIDTH];
  assign sel_z = req_z[grant_idx*ZWIDTH +: ZWIDTH];

  // Issue register: rotator inputs and the tag that travels with them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr       <= '0;
      cor_xi    <= '0;
      cor_yi    <= '0;
      cor_zi    <= '0;
      issue_tag <= '0;
    end else if (transfer) begin
      ptr       <= (grant_idx == CW'(NREQ - 1)) ? '0 : grant_idx + CW'(1);
      cor_xi    <= sel_x;
      cor_yi    <= sel_y;
      cor_zi    <= sel_z;
      issue_tag <= {1'b1, grant_idx};
    end else begin
      cor_xi    <= '0;
      cor_yi    <= '0;
      cor_zi    <= '0;
      issue_tag <= '0;
    end
  end

  // The issued tag then spends LATENCY clocks here, exactly as the sample
  // spends LATENCY clocks inside the rotator, so the last stage lines up
  // with cor_xo/yo/zo.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < LATENCY; k++) begin
        tag_pipe[k] <= '0;
      end
    end else begin
      tag_pipe[0] <= issue_tag;
      for (int k = 1; k < LATENCY; k++) begin
        tag_pipe[k] <= tag_pipe[k-1];
      end
    end
  end

  assign tag_out = tag_pipe[LATENCY-1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      res_valid <= 1'b0;
      res_chan  <= '0;
      res_x     <= '0;
      res_y     <= '0;
      res_z     <= '0;
    end else begin
      res_valid <= tag_out[TW-1];
      if (tag_out[TW-1]) begin
        res_chan <= tag_out[CW-1:0];
        res_x    <= cor_xo;
        res_y    <= cor_yo;
        res_z    <= cor_zo;
      end
    end
  end

  always_comb begin
    busy = issue_tag[TW-1] | res_valid;
    for (int k = 0; k < LATENCY; k++) begin
      busy = busy | tag_pipe[k][TW-1];
    end
  end

endmodule

// File: tb/tb_cordic_rr_sched.sv
// Scoreboard bench for cordic_rr_sched with a quarter-turn rotator model
// delayed by the rotator latency.
module tb_cordic_rr_sched;

  localparam int NREQ = 4;
  localparam int BW   = 16;
  localparam int ZW   = 16;
  localparam int LAT  = 13;

  typedef struct {
    logic [1:0]  chan;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    int          cyc;
  } exp_t;

  logic             clock;
  logic             reset;
  logic [NREQ-1:0]  chan_mask;
  logic [NREQ-1:0]  req_valid;
  logic [NREQ-1:0]  req_ready;
  logic [NREQ*BW-1:0] req_x;
  logic [NREQ*BW-1:0] req_y;
  logic [NREQ*ZW-1:0] req_z;
  logic [BW-1:0]    cor_xi, cor_yi, cor_xo, cor_yo;
  logic [ZW-1:0]    cor_zi, cor_zo;
  logic             res_valid;
  logic [1:0]       res_chan;
  logic [BW-1:0]    res_x, res_y;
  logic [ZW-1:0]    res_z;
  logic             busy;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          mptr = 0;
  logic [15:0] exp_cor_xi = '0;
  logic [15:0] dx [NREQ];
  logic [15:0] dy [NREQ];
  logic [15:0] dz [NREQ];
  int          grant_cnt [NREQ];
  exp_t        sb [$];
  logic [47:0] rp [LAT];

  cordic_rr_sched #(
    .NREQ     (NREQ),
    .BITWIDTH (BW),
    .ZWIDTH   (ZW),
    .LATENCY  (LAT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .chan_mask (chan_mask),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_z     (req_z),
    .cor_xi    (cor_xi),
    .cor_yi    (cor_yi),
    .cor_zi    (cor_zi),
    .cor_xo    (cor_xo),
    .cor_yo    (cor_yo),
    .cor_zo    (cor_zo),
    .res_valid (res_valid),
    .res_chan  (res_chan),
    .res_x     (res_x),
    .res_y     (res_y),
    .res_z     (res_z),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  // Coarse rotator: exact quarter-turn rotation by z[15:14], residual z[13:0].
  function automatic logic [47:0] rot(input logic [15:0] x, input logic [15:0] y,
                                      input logic [15:0] z);
    logic [15:0] rz;
    rz = {2'b00, z[13:0]};
    case (z[15:14])
      2'd0:    return {x, y, rz};
      2'd1:    return {16'(-y), x, rz};
      2'd2:    return {16'(-x), 16'(-y), rz};
      default: return {y, 16'(-x), rz};
    endcase
  endfunction

  initial begin
    for (int i = 0; i < LAT; i++) rp[i] = '0;
  end

  always @(posedge clock) begin
    rp[0] <= {cor_xi, cor_yi, cor_zi};
    for (int i = 1; i < LAT; i++) rp[i] <= rp[i-1];
  end

  assign {cor_xo, cor_yo, cor_zo} = rot(rp[LAT-1][47:32], rp[LAT-1][31:16], rp[LAT-1][15:0]);

  function automatic int model_grant(input logic [NREQ-1:0] elig, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (elig[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fillData(input int seq);
    for (int i = 0; i < NREQ; i++) begin
      dx[i] = 16'(16'h1000 * (i + 1) + seq);
      dy[i] = 16'(seq * 5);
      dz[i] = {2'(i + seq), 14'h0123};
    end
  endtask

  // Called on a falling edge; returns on the next falling edge.
  task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic [NREQ-1:0] mask);
    int   g;
    exp_t e;
    logic [47:0] r;
    checkOutput("cor_xi", 32'(cor_xi), 32'(exp_cor_xi));
    req_valid = valid;
    chan_mask = mask;
    for (int i = 0; i < NREQ; i++) begin
      req_x[i*BW +: BW] = dx[i];
      req_y[i*BW +: BW] = dy[i];
      req_z[i*ZW +: ZW] = dz[i];
    end
    #1;
    g = model_grant(valid & mask, mptr);
    checkOutput("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : 32'(1) << g);
    for (int i = 0; i < NREQ; i++) grant_cnt[i] += int'(req_ready[i]);
    if (g >= 0) begin
      r      = rot(dx[g], dy[g], dz[g]);
      e.chan = 2'(g);
      e.x    = r[47:32];
      e.y    = r[31:16];
      e.z    = r[15:0];
      e.cyc  = cyc + LAT + 2;
      sb.push_back(e);
      exp_cor_xi = dx[g];
      mptr = (g + 1) % NREQ;
    end else begin
      exp_cor_xi = '0;
    end
    @(negedge clock);
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (!reset && res_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected res_valid: got chan %0d expected none", res_chan);
      end else begin
        e = sb.pop_front();
        checkOutput("res_chan", 32'(res_chan), 32'(e.chan));
        checkOutput("res_x", 32'(res_x), 32'(e.x));
        checkOutput("res_y", 32'(res_y), 32'(e.y));
        checkOutput("res_z", 32'(res_z), 32'(e.z));
        checkOutput("res_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1;
    req_valid = '0;
    chan_mask = '0;
    req_x = '0;
    req_y = '0;
    req_z = '0;
    for (int i = 0; i < NREQ; i++) begin
      dx[i] = '0; dy[i] = '0; dz[i] = '0; grant_cnt[i] = 0;
    end
    #12;
    checkOutput("reset req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset res_valid", 32'(res_valid), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset cor_xi", 32'(cor_xi), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    $display("[TB] single request on channel 2");
    dx[2] = 16'h1000; dy[2] = 16'h0000; dz[2] = 16'h4000;
    applyStimulus(4'b0100, 4'b1111);
    for (int i = 0; i < 3; i++) applyStimulus(4'b0000, 4'b1111);
    checkOutput("busy in flight", 32'(busy), 32'd1);
    for (int i = 0; i < 17; i++) applyStimulus(4'b0000, 4'b1111);
    checkOutput("single res_chan", 32'(res_chan), 32'd2);
    checkOutput("single res_x", 32'(res_x), 32'h0000);
    checkOutput("single res_y", 32'(res_y), 32'h1000);
    checkOutput("single res_z", 32'(res_z), 32'h0000);
    checkOutput("busy drained", 32'(busy), 32'd0);

    $display("[TB] wrap from ptr 3 with valid 1001");
    for (int i = 0; i < 6; i++) begin
      fillData(i);
      applyStimulus(4'b1001, 4'b1111);
    end

    $display("[TB] mask 1010 then 0010");
    for (int i = 0; i < 6; i++) begin
      fillData(10 + i);
      applyStimulus(4'b1111, 4'b1010);
    end
    for (int i = 0; i < 3; i++) begin
      fillData(20 + i);
      applyStimulus(4'b1111, 4'b0010);
    end

    $display("[TB] all channels valid for 40 cycles");
    for (int i = 0; i < NREQ; i++) grant_cnt[i] = 0;
    for (int i = 0; i < 40; i++) begin
      fillData(100 + i);
      applyStimulus(4'b1111, 4'b1111);
    end
    for (int i = 0; i < NREQ; i++) checkOutput("fair share", 32'(grant_cnt[i]), 32'd10);

    $display("[TB] sparse random traffic");
    for (int i = 0; i < 60; i++) begin
      logic [NREQ-1:0] v;
      for (int b = 0; b < NREQ; b++) v[b] = ($urandom_range(0, 99) < 30);
      fillData(200 + i);
      applyStimulus(v, 4'b1111);
    end
    for (int i = 0; i < 17; i++) applyStimulus(4'b0000, 4'b1111);
    checkOutput("drain empty", 32'(sb.size()), 32'd0);
    checkOutput("drain busy", 32'(busy), 32'd0);

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 12; i++) begin
      fillData(300 + i);
      applyStimulus(4'b1111, 4'b1111);
    end
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("mid reset req_ready", 32'(req_ready), 32'd0);
    checkOutput("mid reset cor_xi", 32'(cor_xi), 32'd0);
    checkOutput("mid reset res_valid", 32'(res_valid), 32'd0);
    checkOutput("mid reset res_x", 32'(res_x), 32'd0);
    checkOutput("mid reset busy", 32'(busy), 32'd0);
    sb.delete();
    mptr = 0;
    exp_cor_xi = '0;
    req_valid = '0;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) applyStimulus(4'b0000, 4'b1111);
    fillData(400);
    applyStimulus(4'b1111, 4'b1111);
    for (int i = 0; i < 17; i++) applyStimulus(4'b0000, 4'b1111);
    checkOutput("post reset empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
